// File: rtl/rf_arb_pkg.sv
// Shared widths, limits and enums for the register-file port arbiter.
package rf_arb_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned LOCK_MAX = 8;
  localparam int unsigned CNT_W    = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT_LOCK,
    ST_HANDOVER
  } arb_state_e;

endpackage

// File: rtl/rf_arbiter_if.sv
// CPU, EXT loader and register-file signals seen by the arbiter.
interface rf_arbiter_if;
  import rf_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_ad1;
  logic [ADDR_W-1:0] cpu_ad2;
  logic [ADDR_W-1:0] cpu_wa;
  logic [DATA_W-1:0] cpu_wd;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_d1;
  logic [DATA_W-1:0] cpu_d2;

  logic              ext_req;
  logic              ext_lock;
  logic [ADDR_W-1:0] ext_wa;
  logic [DATA_W-1:0] ext_wd;
  logic              ext_gnt;

  logic [ADDR_W-1:0] RF_ad1;
  logic [ADDR_W-1:0] RF_ad2;
  logic [ADDR_W-1:0] RF_wa;
  logic [DATA_W-1:0] RF_wd;
  logic              RF_we;
  logic              RF_external_load;
  logic [DATA_W-1:0] RF_d1;
  logic [DATA_W-1:0] RF_d2;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_ad1, cpu_ad2, cpu_wa, cpu_wd,
    input  ext_req, ext_lock, ext_wa, ext_wd,
    input  RF_d1, RF_d2,
    output cpu_gnt, cpu_rvalid, cpu_d1, cpu_d2, ext_gnt,
    output RF_ad1, RF_ad2, RF_wa, RF_wd, RF_we, RF_external_load
  );

  // Requesters and register file side
  modport master (
    output cpu_req, cpu_we, cpu_ad1, cpu_ad2, cpu_wa, cpu_wd,
    output ext_req, ext_lock, ext_wa, ext_wd,
    output RF_d1, RF_d2,
    input  cpu_gnt, cpu_rvalid, cpu_d1, cpu_d2, ext_gnt,
    input  RF_ad1, RF_ad2, RF_wa, RF_wd, RF_we, RF_external_load
  );

endinterface

// File: rtl/rf_arbiter.sv
// Round-robin arbiter for the register-file port between CPU and EXT loader,
// with a bounded EXT lock followed by a one-cycle handover bubble.
module rf_arbiter
  import rf_arb_pkg::*;
(
  input logic         clk,
  input logic         reset,
  rf_arbiter_if.slave bus
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_rvalid;
  logic              w_cpu_gnt;
  logic              w_ext_gnt;

  // State, RR pointer, lock counter and read-valid registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_CPU;
      r_lock_cnt <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_rvalid   <= w_cpu_gnt;
    end
  end

  // Grant decision and next state; grants are suppressed while reset is high
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_ext_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_lock_cnt;
    w_cnt_inc   = r_lock_cnt + CNT_W'(1);
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_req && (!bus.ext_req || r_owner == OWN_CPU)) begin
            w_cpu_gnt   = 1'b1;
            w_owner_nxt = OWN_EXT;
          end else if (bus.ext_req) begin
            w_ext_gnt   = 1'b1;
            w_owner_nxt = OWN_CPU;
            if (bus.ext_lock) begin
              w_state_nxt = ST_EXT_LOCK;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_EXT_LOCK: begin
          w_ext_gnt = bus.ext_req;
          if (bus.ext_req) begin
            w_cnt_nxt   = w_cnt_inc;
            w_owner_nxt = OWN_CPU;
          end
          if (!bus.ext_lock || (bus.ext_req && w_cnt_inc == CNT_W'(LOCK_MAX))) begin
            w_state_nxt = ST_HANDOVER;
          end
        end
        ST_HANDOVER: begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_CPU;
          w_cnt_nxt   = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_CPU;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Register-file port mux; everything stays zero when nobody is granted
  always_comb begin
    bus.RF_ad1           = '0;
    bus.RF_ad2           = '0;
    bus.RF_wa            = '0;
    bus.RF_wd            = '0;
    bus.RF_we            = 1'b0;
    bus.RF_external_load = 1'b0;
    if (w_cpu_gnt) begin
      bus.RF_ad1 = bus.cpu_ad1;
      bus.RF_ad2 = bus.cpu_ad2;
      bus.RF_wa  = bus.cpu_wa;
      bus.RF_wd  = bus.cpu_wd;
      bus.RF_we  = bus.cpu_we;
    end else if (w_ext_gnt) begin
      bus.RF_wa            = bus.ext_wa;
      bus.RF_wd            = bus.ext_wd;
      bus.RF_external_load = 1'b1;
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.ext_gnt    = w_ext_gnt;
  assign bus.cpu_rvalid = r_rvalid;
  assign bus.cpu_d1     = r_rvalid ? bus.RF_d1 : '0;
  assign bus.cpu_d2     = r_rvalid ? bus.RF_d2 : '0;

endmodule
